// File: rtl/gameplay_control_if.sv
// Gameplay control bundle: player/datapath inputs and control strobes.
// Latency: none, plain wires between controller and datapath.
// Backpressure: none, every strobe is a single-cycle Moore pulse.
// Ports: go, o, c flow towards the controller; sync, enable, ld_x/ld_y/ld_d,
//   save_x, inc_row, inc_score, dec_chances, clear_n, game_over, win, rows
//   flow from it.
interface gameplay_control_if;
  logic       go;
  logic       o;
  logic       c;
  logic       sync;
  logic       enable;
  logic       ld_x;
  logic       ld_y;
  logic       ld_d;
  logic       save_x;
  logic       inc_row;
  logic       inc_score;
  logic       dec_chances;
  logic       clear_n;
  logic       game_over;
  logic       win;
  logic [3:0] rows;

  // Controller side.
  modport master (
    input  go, o, c,
    output sync, enable, ld_x, ld_y, ld_d, save_x, inc_row, inc_score,
           dec_chances, clear_n, game_over, win, rows
  );

  // Datapath / stimulus side.
  modport slave (
    output go, o, c,
    input  sync, enable, ld_x, ld_y, ld_d, save_x, inc_row, inc_score,
           dec_chances, clear_n, game_over, win, rows
  );
endinterface

// File: rtl/gameplay_control.sv
// Gameplay FSM: button sampling, movement tick, drop judging, round/row tracking.
// Latency: button press acts 3 edges after go rises; strobes are Moore, 1 cycle each.
// Backpressure: none; presses outside IDLE/MOVE/OVER/WIN are dropped, not queued.
// Ports: clk, resetn (synchronous, active-low); bus (master modport) carries
//   go/o/c in and all datapath strobes, game status and rows count out.
module gameplay_control #(
  parameter int TICK_DIV = 833333,
  parameter int MAX_ROWS = 12,
  parameter int SETTLE   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  gameplay_control_if.master bus
);

  localparam int CW = $clog2(TICK_DIV);
  // Wide enough for SETTLE-1 and for the 2-cycle wait in MWAIT.
  localparam int WW = $clog2(SETTLE + 2);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_MOVE  = 4'd2,
    S_CHECK = 4'd3,
    S_HIT   = 4'd4,
    S_MISS  = 4'd5,
    S_MWAIT = 4'd6,
    S_OVER  = 4'd7,
    S_WIN   = 4'd8,
    S_CLEAR = 4'd9
  } state_t;

  state_t        state, state_n;
  logic          go_s1, go_s2, go_d;
  logic          press;
  logic [CW-1:0] tick_cnt;
  logic [WW-1:0] wcnt;
  logic [3:0]    rows;
  logic          first;

  // Button: two-flop synchroniser, then an edge register so a held button
  // yields exactly one press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_d  <= 1'b0;
    end else begin
      go_s1 <= bus.go;
      go_s2 <= go_s1;
      go_d  <= go_s2;
    end
  end

  assign press = go_s2 & ~go_d;

  // Free-running movement tick, independent of game state.
  always_ff @(posedge clk) begin
    if (!resetn)
      tick_cnt <= '0;
    else if (tick_cnt == CW'(TICK_DIV - 1))
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CW'(1);
  end

  assign bus.sync = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Wait counter restarts on every state change, so CHECK and MWAIT each
  // begin counting from zero; it saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn)
      wcnt <= '0;
    else if (state_n != state)
      wcnt <= '0;
    else if (wcnt != '1)
      wcnt <= wcnt + WW'(1);
  end

  // Row count and first-drop flag; first drop of a game has nothing below
  // it to overlap, so it is always judged a hit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rows  <= 4'd0;
      first <= 1'b1;
    end else if (state == S_HIT) begin
      first <= 1'b0;
      if (rows != 4'(MAX_ROWS))
        rows <= rows + 4'd1;
    end else if (state == S_CLEAR) begin
      rows  <= 4'd0;
      first <= 1'b1;
    end
  end

  assign bus.rows = rows;

  always_comb begin
    state_n         = state;
    bus.enable      = 1'b0;
    bus.ld_x        = 1'b0;
    bus.ld_y        = 1'b0;
    bus.ld_d        = 1'b0;
    bus.save_x      = 1'b0;
    bus.inc_row     = 1'b0;
    bus.inc_score   = 1'b0;
    bus.dec_chances = 1'b0;
    bus.clear_n     = 1'b1;
    bus.game_over   = 1'b0;
    bus.win         = 1'b0;
    case (state)
      S_IDLE: if (press) state_n = S_LOAD;
      S_LOAD: begin
        bus.ld_x = 1'b1;
        bus.ld_y = 1'b1;
        bus.ld_d = 1'b1;
        state_n  = S_MOVE;
      end
      S_MOVE: begin
        bus.enable = 1'b1;
        if (press) state_n = S_CHECK;
      end
      S_CHECK: begin
        // Give the datapath SETTLE cycles for o to compare the new x.
        if (wcnt == WW'(SETTLE - 1))
          state_n = (first || bus.o) ? S_HIT : S_MISS;
      end
      S_HIT: begin
        bus.save_x    = 1'b1;
        bus.inc_row   = 1'b1;
        bus.inc_score = 1'b1;
        state_n = (({1'b0, rows} + 5'd1) == 5'(MAX_ROWS)) ? S_WIN : S_LOAD;
      end
      S_MISS: begin
        bus.dec_chances = 1'b1;
        state_n         = S_MWAIT;
      end
      S_MWAIT: begin
        // c is registered in the datapath and lags dec_chances by 2 cycles.
        if (wcnt == WW'(1))
          state_n = bus.c ? S_LOAD : S_OVER;
      end
      S_OVER: begin
        bus.game_over = 1'b1;
        if (press) state_n = S_CLEAR;
      end
      S_WIN: begin
        bus.game_over = 1'b1;
        bus.win       = 1'b1;
        if (press) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        bus.clear_n = 1'b0;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
